// File: rtl/ysyx_24070017_wbu_pkg.sv
// rtl/ysyx_24070017_wbu_pkg.sv - shared register-file constants and write-back entry type
package ysyx_24070017_wbu_pkg;
   localparam int ysyx_24070017_WORD_LENGTH = 32;
   localparam int ysyx_24070017_RF_REG_NUM  = 32;
   localparam int ysyx_24070017_ADDR_W      = $clog2(ysyx_24070017_RF_REG_NUM);

   typedef struct packed {
      logic [ysyx_24070017_ADDR_W-1:0]      rd;
      logic [ysyx_24070017_WORD_LENGTH-1:0] data;
   } res_entry_t;
endpackage

// File: rtl/ysyx_24070017_wbu_fifo2.sv
// rtl/ysyx_24070017_wbu_fifo2.sv - two-entry synchronous FIFO for buffered results
module ysyx_24070017_wbu_fifo2
   import ysyx_24070017_wbu_pkg::*;
#(
   parameter int W = $bits(res_entry_t)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         wr_ptr;

   // Caller never pushes when full nor pops when empty.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_ptr   = rd_ptr_q ^ count_q[0];
      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
      end else begin
         if (push) mem_d[wr_ptr] = din;
         if (pop) rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/ysyx_24070017_wbu.sv
// rtl/ysyx_24070017_wbu.sv - write-back unit: result buffer, RF write port and pending-write scoreboard
module ysyx_24070017_wbu
   import ysyx_24070017_wbu_pkg::*;
#(
   parameter int WORD_LENGTH = ysyx_24070017_WORD_LENGTH,
   parameter int RF_REG_NUM  = ysyx_24070017_RF_REG_NUM,
   parameter int ADDR_W      = $clog2(RF_REG_NUM)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic                             iss_valid,
   input  logic [ADDR_W-1:0]                iss_rd,
   output logic                             iss_ready,
   input  logic                             res_valid,
   input  logic [ADDR_W-1:0]                res_rd,
   input  logic [WORD_LENGTH-1:0]           res_data,
   output logic                             res_ready,
   output logic [RF_REG_NUM-1:0]            we,
   output logic [RF_REG_NUM*WORD_LENGTH-1:0] wdata,
   output logic [RF_REG_NUM-1:0]            busy
);
   logic [1:0]                         count;
   logic [ADDR_W+WORD_LENGTH-1:0]      head;
   logic [ADDR_W-1:0]                  head_rd;
   logic [WORD_LENGTH-1:0]             head_data;
   logic                               push, pop, inc, dec;
   logic [RF_REG_NUM-1:0]              we_q, we_d;
   logic [RF_REG_NUM*WORD_LENGTH-1:0]  wdata_q, wdata_d;
   logic [1:0]                         pend_q [RF_REG_NUM];
   logic [1:0]                         pend_d [RF_REG_NUM];

   assign res_ready = (count != 2'd2);
   assign push      = res_valid && res_ready;
   assign pop       = (count != 2'd0);
   assign head_rd   = head[ADDR_W+WORD_LENGTH-1:WORD_LENGTH];
   assign head_data = head[WORD_LENGTH-1:0];

   ysyx_24070017_wbu_fifo2 #(.W(ADDR_W + WORD_LENGTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push),
      .din   ({res_rd, res_data}),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

   // Readiness looks only at registered counts; a same-cycle commit does not help.
   assign iss_ready = (iss_rd == '0) || (pend_q[iss_rd] != 2'd3);
   assign inc       = iss_valid && iss_ready && (iss_rd != '0);
   assign dec       = pop && (head_rd != '0);

   always_comb begin
      we_d      = '0;
      wdata_d   = wdata_q;
      pend_d    = pend_q;
      pend_d[0] = 2'd0;
      if (flush) begin
         for (int i = 1; i < RF_REG_NUM; i++) pend_d[i] = 2'd0;
      end else begin
         if (pop) begin
            wdata_d = {RF_REG_NUM{head_data}};
            if (head_rd != '0) we_d[head_rd] = 1'b1;
         end
         for (int i = 1; i < RF_REG_NUM; i++) begin
            if (inc && (iss_rd == ADDR_W'(i)) && !(dec && (head_rd == ADDR_W'(i))))
               pend_d[i] = pend_q[i] + 2'd1;
            else if (dec && (head_rd == ADDR_W'(i)) && !(inc && (iss_rd == ADDR_W'(i)))
                     && (pend_q[i] != 2'd0))
               pend_d[i] = pend_q[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= '0;
         wdata_q <= '0;
         for (int i = 0; i < RF_REG_NUM; i++) pend_q[i] <= 2'd0;
      end else begin
         we_q    <= we_d;
         wdata_q <= wdata_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 1; i < RF_REG_NUM; i++) busy[i] = (pend_q[i] != 2'd0);
   end

   assign we    = we_q;
   assign wdata = wdata_q;

   underflow_a: assert property (@(posedge clk) disable iff (!rst)
      !(dec && !flush && (pend_q[head_rd] == 2'd0)));
endmodule

// File: tb/tb_ysyx_24070017_wbu.sv
// tb/tb_ysyx_24070017_wbu.sv - directed vector bench for the write-back unit
module tb_ysyx_24070017_wbu;
   logic         clk = 1'b0;
   logic         rst;
   logic         flush, iss_valid, res_valid;
   logic [4:0]   iss_rd, res_rd;
   logic [31:0]  res_data;
   logic         iss_ready, res_ready;
   logic [31:0]  we, busy;
   logic [1023:0] wdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        iv;
      logic [4:0]  ird;
      logic        rv;
      logic [4:0]  rrd;
      logic [31:0] rdata;
      logic        fl;
      logic [31:0] e_we;
      logic [31:0] e_busy;
      logic        e_ir;
      logic        e_rr;
      int          wd_idx;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vq[$];

   ysyx_24070017_wbu dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .iss_ready (iss_ready),
      .res_valid (res_valid),
      .res_rd    (res_rd),
      .res_data  (res_data),
      .res_ready (res_ready),
      .we        (we),
      .wdata     (wdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [4:0] ird, input logic rv, input logic [4:0] rrd,
                      input logic [31:0] rdata, input logic fl, input logic [31:0] e_we,
                      input logic [31:0] e_busy, input logic e_ir, input logic e_rr,
                      input int wd_idx, input logic [31:0] e_wd);
      vec_t v;
      v.iv = iv; v.ird = ird; v.rv = rv; v.rrd = rrd; v.rdata = rdata; v.fl = fl;
      v.e_we = e_we; v.e_busy = e_busy; v.e_ir = e_ir; v.e_rr = e_rr;
      v.wd_idx = wd_idx; v.e_wd = e_wd;
      vq.push_back(v);
   endtask

   task automatic idle_in();
      iss_valid = 0; iss_rd = 0; res_valid = 0; res_rd = 0; res_data = 0; flush = 0;
   endtask

   initial begin
      idle_in();
      rst = 1'b0;
      #1;
      chk("reset we", we, 32'h0);
      chk("reset busy", busy, 32'h0);
      chk("reset wdata", wdata[31:0], 32'h0);
      chk("reset res_ready", {31'd0, res_ready}, 32'd1);
      chk("reset iss_ready", {31'd0, iss_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      //   iv ird rv rrd data         fl we          busy        ir rr wd  e_wd
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, 0,  32'h0);        // 0
      add(1, 5,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 1
      add(0, 0,  1, 5, 32'hDEADBEEF, 0, 32'h0,      32'h20,     1, 1, -1, 32'h0);        // 2
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h20,     1, 1, -1, 32'h0);        // 3
      add(0, 0,  0, 0, 32'h0,        0, 32'h20,     32'h0,      1, 1, 5,  32'hDEADBEEF); // 4
      add(1, 0,  1, 0, 32'h1234,     0, 32'h0,      32'h0,      1, 1, 5,  32'hDEADBEEF); // 5
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 6
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, 0,  32'h1234);     // 7
      add(1, 1,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 8
      add(1, 2,  0, 0, 32'h0,        0, 32'h0,      32'h2,      1, 1, -1, 32'h0);        // 9
      add(1, 3,  0, 0, 32'h0,        0, 32'h0,      32'h6,      1, 1, -1, 32'h0);        // 10
      add(0, 0,  1, 1, 32'h11,       0, 32'h0,      32'hE,      1, 1, -1, 32'h0);        // 11
      add(0, 0,  1, 2, 32'h22,       0, 32'h0,      32'hE,      1, 1, -1, 32'h0);        // 12
      add(0, 0,  1, 3, 32'h33,       0, 32'h2,      32'hC,      1, 1, 1,  32'h11);       // 13
      add(0, 0,  0, 0, 32'h0,        0, 32'h4,      32'h8,      1, 1, 2,  32'h22);       // 14
      add(0, 0,  0, 0, 32'h0,        0, 32'h8,      32'h0,      1, 1, 3,  32'h33);       // 15
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 16
      add(1, 7,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 17
      add(1, 7,  0, 0, 32'h0,        0, 32'h0,      32'h80,     1, 1, -1, 32'h0);        // 18
      add(1, 7,  0, 0, 32'h0,        0, 32'h0,      32'h80,     1, 1, -1, 32'h0);        // 19
      add(1, 7,  1, 7, 32'h77,       0, 32'h0,      32'h80,     0, 1, -1, 32'h0);        // 20
      add(1, 7,  0, 0, 32'h0,        0, 32'h0,      32'h80,     0, 1, -1, 32'h0);        // 21
      add(0, 7,  1, 7, 32'h78,       0, 32'h80,     32'h80,     1, 1, 7,  32'h77);       // 22
      add(0, 0,  1, 7, 32'h79,       0, 32'h0,      32'h80,     1, 1, -1, 32'h0);        // 23
      add(0, 0,  0, 0, 32'h0,        0, 32'h80,     32'h80,     1, 1, 7,  32'h78);       // 24
      add(0, 0,  0, 0, 32'h0,        0, 32'h80,     32'h0,      1, 1, 7,  32'h79);       // 25
      add(1, 9,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 26
      add(0, 0,  1, 9, 32'h99,       0, 32'h0,      32'h200,    1, 1, -1, 32'h0);        // 27
      add(1, 9,  0, 0, 32'h0,        0, 32'h0,      32'h200,    1, 1, -1, 32'h0);        // 28
      add(0, 0,  1, 9, 32'h9A,       0, 32'h200,    32'h200,    1, 1, 9,  32'h99);       // 29
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h200,    1, 1, -1, 32'h0);        // 30
      add(0, 0,  0, 0, 32'h0,        0, 32'h200,    32'h0,      1, 1, 9,  32'h9A);       // 31
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 32
      add(1, 4,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 33
      add(1, 6,  0, 0, 32'h0,        0, 32'h0,      32'h10,     1, 1, -1, 32'h0);        // 34
      add(0, 0,  1, 4, 32'h44,       0, 32'h0,      32'h50,     1, 1, -1, 32'h0);        // 35
      add(1, 6,  1, 6, 32'h66,       1, 32'h0,      32'h50,     1, 1, -1, 32'h0);        // 36
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 37
      add(0, 0,  0, 0, 32'h0,        0, 32'h0,      32'h0,      1, 1, -1, 32'h0);        // 38

      foreach (vq[k]) begin
         @(negedge clk);
         iss_valid = vq[k].iv;  iss_rd = vq[k].ird;
         res_valid = vq[k].rv;  res_rd = vq[k].rrd; res_data = vq[k].rdata;
         flush     = vq[k].fl;
         #1;
         chk($sformatf("row%0d we", k), we, vq[k].e_we);
         chk($sformatf("row%0d busy", k), busy, vq[k].e_busy);
         chk($sformatf("row%0d iss_ready", k), {31'd0, iss_ready}, {31'd0, vq[k].e_ir});
         chk($sformatf("row%0d res_ready", k), {31'd0, res_ready}, {31'd0, vq[k].e_rr});
         if (vq[k].wd_idx >= 0)
            chk($sformatf("row%0d wdata[%0d]", k, vq[k].wd_idx),
                wdata[vq[k].wd_idx*32 +: 32], vq[k].e_wd);
      end

      // Asynchronous reset while a write pulse is on the port.
      @(negedge clk); idle_in(); iss_valid = 1; iss_rd = 3;
      @(negedge clk); iss_rd = 10;
      @(negedge clk); idle_in(); res_valid = 1; res_rd = 3; res_data = 32'hABC;
      @(negedge clk); idle_in();
      @(negedge clk);
      chk("pre-reset we", we, 32'h8);
      chk("pre-reset busy", busy, 32'h400);
      chk("pre-reset wdata[3]", wdata[3*32 +: 32], 32'hABC);
      #1 rst = 1'b0;
      #1;
      chk("async reset we", we, 32'h0);
      chk("async reset busy", busy, 32'h0);
      chk("async reset wdata[3]", wdata[3*32 +: 32], 32'h0);
      @(negedge clk); rst = 1'b1;
      #1;
      chk("post-reset res_ready", {31'd0, res_ready}, 32'd1);
      chk("post-reset iss_ready", {31'd0, iss_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ysyx_24070017_wbu.md
# ysyx_24070017_wbu

Write-back unit that feeds the register file's write port. Takes completed results `(rd, data)` over a valid/ready handshake, buffers up to two of them, and drains one per cycle into the RF as a registered one-hot `we` vector plus flattened `wdata`. It also keeps a per-register pending-write scoreboard (`busy`) that the issue stage uses for RAW hazard checks. It sits between the execute/LSU result path and the RF.

## Interface
Parameters:
- `WORD_LENGTH`, 32, data width of one register
- `RF_REG_NUM`, 32, number of registers; register 0 is hard-wired zero
- `ADDR_W`, `$clog2(RF_REG_NUM)`, register index width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `flush`  in  1  synchronous clear of buffer and scoreboard
- `iss_valid`  in  1  issue stage announces a future write to `iss_rd`
- `iss_rd`  in  `ADDR_W`  destination of the announced write
- `iss_ready`  out  1  announcement accepted this cycle
- `res_valid`  in  1  result available
- `res_rd`  in  `ADDR_W`  result destination
- `res_data`  in  `WORD_LENGTH`  result value
- `res_ready`  out  1  result accepted this cycle
- `we`  out  `RF_REG_NUM`  one-hot RF write enable, registered
- `wdata`  out  `RF_REG_NUM*WORD_LENGTH`  flattened RF write data; every slice carries the same value, registered
- `busy`  out  `RF_REG_NUM`  bit i = at least one announced write to xi not yet committed; bit 0 always 0

## Operation
- **Result buffer:** 2-entry FIFO of `{rd, data}` with count 0..2.
  - Push when `res_valid && res_ready`.
  - `res_ready = (count != 2)`, driven from registered state only. No push-through when full.
- **Drain:** when count > 0, pop the head every cycle. On the next edge:
  - `we` gets the one-hot of head `rd`, except `rd == 0`, which gives `we = 0`. The entry is still popped and its scoreboard untouched.
  - every `wdata` slice gets head `data`.
  - With nothing popped, `we = 0` and `wdata` holds its previous value.
- **Same-cycle push and pop:** push and pop in one cycle are legal; count is unchanged and order is preserved.
- **Scoreboard:** per-register 2-bit pending counter `pend[i]`, i = 1..RF_REG_NUM-1; `busy[i] = (pend[i] != 0)`.
  - **Increment:** on `iss_valid && iss_ready && iss_rd != 0`.
  - **Decrement:** on pop of an entry with `rd != 0`.
  - **Same register both ways:** counter unchanged.
  - **`iss_ready`:** `!(pend[iss_rd] == 3)`. Combinational from the registered counter; it ignores a same-cycle decrement.
  - **`iss_rd == 0`:** `iss_ready = 1`, no effect.
  - **Underflow:** a pop with `pend == 0` is a protocol error. The counter saturates at 0. Assertion only in simulation.
- **`flush`** (highest priority after reset):
  - FIFO count becomes 0 and all `pend` become 0.
  - `we = 0` next cycle.
  - `res_ready` and `iss_ready` are still computed from pre-flush state.
  - A push or increment in the flush cycle is discarded.

## Timing
- **Reset values:**
  - `we = 0`
  - `wdata = 0`
  - `busy = 0`
  - FIFO empty, `res_ready = 1`, `iss_ready = 1`
- **Latency:** a result accepted at edge N with FIFO empty (and not popping) is visible in `we`/`wdata` after edge N+1. The RF captures it at edge N+2.
- **`busy` after commit:** `busy[rd]` falls after the same edge that raises `we[rd]`, provided no other write to `rd` is pending.
- **Throughput:** one write per cycle sustained. With a continuous `res_valid`, `res_ready` stays 1.
- **Reset mid-operation:** asserting `rst` clears everything asynchronously. An in-flight `we` pulse is dropped immediately.

## Structure
- Shared package holds `ysyx_24070017_WORD_LENGTH`, `ysyx_24070017_RF_REG_NUM` and the `{rd, data}` result entry typedef. The RF uses the same constants.
- Natural sub-module: `ysyx_24070017_wbu_fifo2`, a 2-entry synchronous FIFO with `push`/`pop`/`count`/`flush`. The scoreboard and output registers stay in the top.

## Test plan
- **Single write:** reset, then `res_valid=1`, `rd=5`, `data=0xDEADBEEF` for one cycle → two edges later `we = 32'h20`, slice 5 of `wdata` = `0xDEADBEEF`, one-cycle pulse.
- **x0 drop:** `res_rd=0`, `data=0x1234` → `we` stays 0 and FIFO drains. Issue `iss_rd=0` → `busy` stays 0.
- **Back-pressure:** hold `res_valid` with `rd` values 1, 2, 3 while popping is forced by a stalled-pop test hook, or equivalently by checking count → `res_ready` drops at count 2. Commit order is 1, 2, 3 with no loss.
- **Scoreboard:**
  - Three issues to x7 → `busy[7]=1`, `iss_ready` low on a fourth x7 issue.
  - Commit one x7 → `iss_ready` high next cycle.
  - Commit the remaining two → `busy[7]=0`.
- **Simultaneous issue and commit:** issue x9 and commit x9 in the same cycle with `pend[9]=1` → `pend[9]` stays 1 and `busy[9]` stays 1.
- **Flush and reset:**
  - 2 entries buffered plus `busy` bits set, assert `flush` → next cycle `we=0`, `busy=0`, `res_ready=1`.
  - Repeat with `rst` asserted mid-pulse → `we` goes to 0 without waiting for a clock edge.
